// File: rtl/i2c_target_pkg.sv
// rtl/i2c_target_pkg.sv - shared types and bus constants for the I2C register target
package i2c_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } state_t;

  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_in_filter.sv
// rtl/i2c_in_filter.sv - pin synchronizer, stable-level glitch filter and edge detect
module i2c_in_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // level follows the pin only once it has held a new value for FILTER_LEN clocks;
  // rise/fall pulse in the same cycle that level changes
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= sync2;
        rise  <= sync2;
        fall  <= ~sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target with a STATUS register and read/write control registers
module i2c_target_regs
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter int         NREGS      = 8,
  parameter int         FILTER_LEN = 3
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset,
  input  logic                       scl_in,
  input  logic                       sda_in,
  output logic                       sda_oe,
  input  logic [7:0]                 status_in,
  output logic [8*(NREGS-1)-1:0]     ctrl_out,
  output logic                       wr_strobe,
  output logic [$clog2(NREGS)-1:0]   wr_index,
  output logic                       busy
);

  localparam int PW = $clog2(NREGS);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk(clk_clk), .reset(reset_reset), .pin(scl_in),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_in_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk(clk_clk), .reset(reset_reset), .pin(sda_in),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  state_t        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          sda_oe_d, busy_d, wr_en;
  logic [7:0]    rx_byte, rd_byte;
  logic          scl_stable, start_det, stop_det;

  // a same-cycle SCL edge wins over any SDA edge
  assign scl_stable = scl_lvl & ~scl_rise & ~scl_fall;
  assign start_det  = sda_fall & scl_stable;
  assign stop_det   = sda_rise & scl_stable;

  always_comb begin
    rd_byte = status_in;
    for (int i = 1; i < NREGS; i++)
      if (ptr_q == PW'(i)) rd_byte = ctrl_out[8*i-8 +: 8];
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe;
    busy_d    = busy;
    wr_en     = 1'b0;
    rx_byte   = {shift_q[6:0], sda_lvl};
    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (bit_cnt_q != 4'd8) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7 && state_q == ST_PTR) ptr_d = rx_byte[PW-1:0];
            if (bit_cnt_q == 4'd7 && state_q == ST_WDATA) begin
              wr_en = (ptr_q != '0);
              ptr_d = ptr_q + PW'(1);
            end
          end
        end
        ST_RDATA:     if (bit_cnt_q != 4'd8) bit_cnt_d = bit_cnt_q + 4'd1;
        ST_RDATA_ACK: shift_d[0] = sda_lvl;  // controller's ACK/NACK
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        ST_ADDR: if (bit_cnt_q == 4'd8) begin
          bit_cnt_d = '0;
          if (shift_q[7:1] == DEV_ADDR) begin
            state_d  = ST_ADDR_ACK;
            sda_oe_d = 1'b1;
          end else begin
            state_d  = ST_IGNORE;
          end
        end
        ST_PTR: if (bit_cnt_q == 4'd8) begin
          state_d   = ST_PTR_ACK;
          bit_cnt_d = '0;
          sda_oe_d  = 1'b1;
        end
        ST_WDATA: if (bit_cnt_q == 4'd8) begin
          state_d   = ST_WDATA_ACK;
          bit_cnt_d = '0;
          sda_oe_d  = 1'b1;
        end
        ST_ADDR_ACK: begin
          bit_cnt_d = '0;
          if (shift_q[0] == I2C_RW_READ) begin
            state_d  = ST_RDATA;
            shift_d  = rd_byte;
            sda_oe_d = ~rd_byte[7];
          end else begin
            state_d  = ST_PTR;
            sda_oe_d = 1'b0;
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          state_d   = ST_WDATA;
          bit_cnt_d = '0;
          sda_oe_d  = 1'b0;
        end
        ST_RDATA: begin
          if (bit_cnt_q == 4'd8) begin
            state_d   = ST_RDATA_ACK;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            ptr_d     = ptr_q + PW'(1);
          end else begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
        end
        ST_RDATA_ACK: begin
          if (shift_q[0] == I2C_ACK) begin
            state_d  = ST_RDATA;
            shift_d  = rd_byte;
            sda_oe_d = ~rd_byte[7];
          end else begin
            state_d  = ST_IGNORE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      ctrl_out  <= '0;
      wr_strobe <= 1'b0;
      wr_index  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      sda_oe    <= sda_oe_d;
      busy      <= busy_d;
      wr_strobe <= wr_en;
      if (wr_en) begin
        wr_index <= ptr_q;
        for (int i = 1; i < NREGS; i++)
          if (ptr_q == PW'(i)) ctrl_out[8*i-8 +: 8] <= rx_byte;
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb/tb_i2c_target_regs.sv - bus-level bench for the I2C register target
module tb_i2c_target_regs;
  import i2c_target_pkg::*;

  localparam int NREGS = 8;
  localparam int Q     = 8;
  localparam logic [7:0] ADDR_W = {7'h50, I2C_RW_WRITE};
  localparam logic [7:0] ADDR_R = {7'h50, I2C_RW_READ};

  logic clk = 1'b0;
  logic reset_reset, scl_m, sda_m, glitch_en;
  logic scl_in, sda_in, sda_oe, wr_strobe, busy;
  logic [7:0] status_in;
  logic [8*(NREGS-1)-1:0] ctrl_out;
  logic [2:0] wr_index;

  int tests = 0;
  int fails = 0;
  logic [7:0]  model [NREGS];
  logic [10:0] exp_wr [$];
  logic [10:0] obs_wr [$];
  logic [7:0]  exp_rd [$];
  logic [10:0] e11, o11;
  logic [7:0]  e8, tmp8;
  logic [7:0]  got [4];
  logic        nack, ack;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_regs #(.DEV_ADDR(7'h50), .NREGS(NREGS), .FILTER_LEN(3)) dut (
    .clk_clk(clk), .reset_reset(reset_reset), .scl_in(scl_in), .sda_in(sda_in),
    .sda_oe(sda_oe), .status_in(status_in), .ctrl_out(ctrl_out),
    .wr_strobe(wr_strobe), .wr_index(wr_index), .busy(busy)
  );

  function automatic logic [7:0] ctrl_byte(input int idx);
    logic [8*(NREGS-1)-1:0] v;
    v = ctrl_out;
    ctrl_byte = 8'h00;
    for (int i = 1; i < NREGS; i++) if (i == idx) ctrl_byte = v[8*i-8 +: 8];
  endfunction

  function automatic logic [8*(NREGS-1)-1:0] model_ctrl();
    logic [8*(NREGS-1)-1:0] v;
    for (int i = 1; i < NREGS; i++) v[8*i-8 +: 8] = model[i];
    return v;
  endfunction

  always @(negedge clk) if (wr_strobe) obs_wr.push_back({wr_index, ctrl_byte(int'(wr_index))});

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_bit(input logic b);
    wait_clks(Q/2);
    if (glitch_en) begin scl_m = 1'b1; wait_clks(1); scl_m = 1'b0; wait_clks(Q/2 - 1); end
    else wait_clks(Q/2);
    sda_m = b;
    wait_clks(Q);
    scl_m = 1'b1;
    if (glitch_en) begin wait_clks(Q); scl_m = 1'b0; wait_clks(1); scl_m = 1'b1; wait_clks(Q - 1); end
    else wait_clks(2*Q);
    scl_m = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    wait_clks(Q); sda_m = 1'b1;
    wait_clks(Q); scl_m = 1'b1;
    wait_clks(Q); b = sda_in;
    wait_clks(Q); scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic a);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(a);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic a);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    write_bit(a);
  endtask

  task automatic i2c_start();
    if (scl_m == 1'b0) begin wait_clks(Q); sda_m = 1'b1; wait_clks(Q); scl_m = 1'b1; end
    wait_clks(Q); sda_m = 1'b0;
    wait_clks(Q); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clks(Q); sda_m = 1'b0;
    wait_clks(Q); scl_m = 1'b1;
    wait_clks(Q); sda_m = 1'b1;
    wait_clks(2*Q);
  endtask

  task automatic write_regs(input logic [7:0] ptr, input logic [7:0] d0, input logic [7:0] d1,
                            input int n, output logic any_nack);
    logic a;
    int idx;
    logic [7:0] d;
    any_nack = 1'b0;
    i2c_start();
    write_byte(ADDR_W, a); any_nack |= a;
    write_byte(ptr, a);    any_nack |= a;
    idx = int'(ptr) % NREGS;
    for (int k = 0; k < n; k++) begin
      d = (k == 0) ? d0 : d1;
      if (idx != 0) begin model[idx] = d; exp_wr.push_back({3'(idx), d}); end
      write_byte(d, a); any_nack |= a;
      idx = (idx + 1) % NREGS;
    end
    i2c_stop();
  endtask

  task automatic read_regs(input logic [7:0] ptr, input int n, output logic any_nack,
                           output logic [7:0] g [4]);
    logic a;
    int idx;
    any_nack = 1'b0;
    for (int k = 0; k < 4; k++) g[k] = 8'h00;
    i2c_start();
    write_byte(ADDR_W, a); any_nack |= a;
    write_byte(ptr, a);    any_nack |= a;
    i2c_start();
    write_byte(ADDR_R, a); any_nack |= a;
    idx = int'(ptr) % NREGS;
    for (int k = 0; k < n; k++) begin
      exp_rd.push_back(idx == 0 ? status_in : model[idx]);
      read_byte(g[k], (k == n - 1) ? I2C_NACK : I2C_ACK);
      idx = (idx + 1) % NREGS;
    end
  endtask

  task automatic test_reset();
    tests++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL reset_sda_oe: got %b, expected 0", sda_oe); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    tests++; if (wr_strobe !== 1'b0) begin fails++; $display("FAIL reset_wr_strobe: got %b, expected 0", wr_strobe); end
    tests++; if (wr_index !== 3'd0) begin fails++; $display("FAIL reset_wr_index: got %0d, expected 0", wr_index); end
    tests++; if (ctrl_out !== '0) begin fails++; $display("FAIL reset_ctrl_out: got %h, expected 0", ctrl_out); end
  endtask

  task automatic test_write_ptr();
    write_regs(8'h02, 8'h5A, 8'h00, 1, nack);
    tests++; if (nack !== 1'b0) begin fails++; $display("FAIL write_acks: got nack %b, expected 0", nack); end
    tests++; if (ctrl_byte(2) !== 8'h5A) begin fails++; $display("FAIL write_reg2: got %h, expected 5a", ctrl_byte(2)); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL write_busy_after_stop: got %b, expected 0", busy); end
    tests++;
    if (obs_wr.size() != exp_wr.size()) begin fails++; $display("FAIL write_strobe_count: got %0d, expected %0d", obs_wr.size(), exp_wr.size()); end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e11 = exp_wr.pop_front(); o11 = obs_wr.pop_front(); tests++;
      if (o11 !== e11) begin fails++; $display("FAIL write_strobe: got idx/data %h, expected %h", o11, e11); end
    end
    exp_wr.delete(); obs_wr.delete();
  endtask

  task automatic test_read_status();
    status_in = 8'hA5;
    read_regs(8'h00, 1, nack, got);
    tests++; if (nack !== 1'b0) begin fails++; $display("FAIL status_acks: got nack %b, expected 0", nack); end
    e8 = exp_rd.pop_front(); tests++;
    if (got[0] !== e8) begin fails++; $display("FAIL status_read: got %h, expected %h", got[0], e8); end
    wait_clks(Q);
    tests++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL status_release_after_nack: got %b, expected 0", sda_oe); end
    i2c_stop();
  endtask

  task automatic test_wrong_addr();
    i2c_start();
    write_byte({7'h51, I2C_RW_WRITE}, ack);
    tests++; if (ack !== I2C_NACK) begin fails++; $display("FAIL wrong_addr_ack: got %b, expected 1", ack); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL wrong_addr_busy: got %b, expected 1", busy); end
    write_byte(8'h33, ack);
    tests++; if (ack !== I2C_NACK) begin fails++; $display("FAIL wrong_addr_data_ack: got %b, expected 1", ack); end
    i2c_stop();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL wrong_addr_busy_stop: got %b, expected 0", busy); end
    tests++; if (ctrl_out !== model_ctrl()) begin fails++; $display("FAIL wrong_addr_regs: got %h, expected %h", ctrl_out, model_ctrl()); end
    tests++; if (obs_wr.size() != 0) begin fails++; $display("FAIL wrong_addr_strobe: got %0d strobes, expected 0", obs_wr.size()); end
    obs_wr.delete();
  endtask

  task automatic test_wrap();
    write_regs(8'h06, 8'h66, 8'h00, 1, nack);
    tests++; if (nack !== 1'b0) begin fails++; $display("FAIL wrap_reg6_acks: got nack %b, expected 0", nack); end
    write_regs(8'h07, 8'h11, 8'h22, 2, nack);
    tests++; if (nack !== 1'b0) begin fails++; $display("FAIL wrap_acks: got nack %b, expected 0", nack); end
    tests++; if (ctrl_byte(7) !== 8'h11) begin fails++; $display("FAIL wrap_reg7: got %h, expected 11", ctrl_byte(7)); end
    tests++; if (ctrl_out !== model_ctrl()) begin fails++; $display("FAIL wrap_regs: got %h, expected %h", ctrl_out, model_ctrl()); end
    tests++;
    if (obs_wr.size() != exp_wr.size()) begin fails++; $display("FAIL wrap_strobe_count: got %0d, expected %0d", obs_wr.size(), exp_wr.size()); end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e11 = exp_wr.pop_front(); o11 = obs_wr.pop_front(); tests++;
      if (o11 !== e11) begin fails++; $display("FAIL wrap_strobe: got idx/data %h, expected %h", o11, e11); end
    end
    exp_wr.delete(); obs_wr.delete();
    read_regs(8'h06, 3, nack, got);
    i2c_stop();
    tests++; if (nack !== 1'b0) begin fails++; $display("FAIL wrap_read_acks: got nack %b, expected 0", nack); end
    for (int k = 0; k < 3; k++) begin
      e8 = exp_rd.pop_front(); tests++;
      if (got[k] !== e8) begin fails++; $display("FAIL wrap_read[%0d]: got %h, expected %h", k, got[k], e8); end
    end
  endtask

  task automatic test_stop_partial();
    i2c_start();
    write_byte(ADDR_W, ack);
    write_byte(8'h03, ack);
    for (int i = 0; i < 4; i++) write_bit(i[0]);
    i2c_stop();
    tests++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL partial_sda_oe: got %b, expected 0", sda_oe); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL partial_busy: got %b, expected 0", busy); end
    tests++; if (ctrl_out !== model_ctrl()) begin fails++; $display("FAIL partial_regs: got %h, expected %h", ctrl_out, model_ctrl()); end
    tests++; if (obs_wr.size() != 0) begin fails++; $display("FAIL partial_strobe: got %0d strobes, expected 0", obs_wr.size()); end
    obs_wr.delete();
  endtask

  task automatic test_reset_mid();
    i2c_start();
    write_byte(ADDR_W, ack);
    write_byte(8'h01, ack);
    i2c_start();
    write_byte(ADDR_R, ack);
    for (int i = 0; i < 4; i++) read_bit(tmp8[7-i]);
    wait_clks(Q);
    tests++; if (sda_oe !== ~model[1][3]) begin fails++; $display("FAIL mid_bit3_drive: got %b, expected %b", sda_oe, ~model[1][3]); end
    reset_reset = 1'b1;
    wait_clks(1);
    for (int i = 0; i < NREGS; i++) model[i] = 8'h00;
    tests++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL mid_reset_sda_oe: got %b, expected 0", sda_oe); end
    tests++; if (ctrl_out !== model_ctrl()) begin fails++; $display("FAIL mid_reset_ctrl: got %h, expected %h", ctrl_out, model_ctrl()); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_reset_busy: got %b, expected 0", busy); end
    reset_reset = 1'b0;
    obs_wr.delete(); exp_wr.delete();
    sda_m = 1'b1; wait_clks(Q); scl_m = 1'b1; wait_clks(2*Q);
    write_regs(8'h04, 8'h3C, 8'h00, 1, nack);
    tests++; if (nack !== 1'b0) begin fails++; $display("FAIL mid_after_acks: got nack %b, expected 0", nack); end
    tests++;
    if (obs_wr.size() != exp_wr.size()) begin fails++; $display("FAIL mid_strobe_count: got %0d, expected %0d", obs_wr.size(), exp_wr.size()); end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e11 = exp_wr.pop_front(); o11 = obs_wr.pop_front(); tests++;
      if (o11 !== e11) begin fails++; $display("FAIL mid_strobe: got idx/data %h, expected %h", o11, e11); end
    end
    exp_wr.delete(); obs_wr.delete();
    read_regs(8'h04, 1, nack, got);
    i2c_stop();
    e8 = exp_rd.pop_front(); tests++;
    if (got[0] !== e8) begin fails++; $display("FAIL mid_readback: got %h, expected %h", got[0], e8); end
  endtask

  task automatic test_glitch();
    glitch_en = 1'b1;
    write_regs(8'h05, 8'h77, 8'h00, 1, nack);
    glitch_en = 1'b0;
    tests++; if (nack !== 1'b0) begin fails++; $display("FAIL glitch_acks: got nack %b, expected 0", nack); end
    tests++; if (ctrl_out !== model_ctrl()) begin fails++; $display("FAIL glitch_regs: got %h, expected %h", ctrl_out, model_ctrl()); end
    tests++;
    if (obs_wr.size() != exp_wr.size()) begin fails++; $display("FAIL glitch_strobe_count: got %0d, expected %0d", obs_wr.size(), exp_wr.size()); end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e11 = exp_wr.pop_front(); o11 = obs_wr.pop_front(); tests++;
      if (o11 !== e11) begin fails++; $display("FAIL glitch_strobe: got idx/data %h, expected %h", o11, e11); end
    end
    exp_wr.delete(); obs_wr.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    reset_reset = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    glitch_en = 1'b0;
    status_in = 8'hA5;
    for (int i = 0; i < NREGS; i++) model[i] = 8'h00;
    wait_clks(5);
    reset_reset = 1'b0;
    test_reset();
    wait_clks(Q);
    test_write_ptr();
    test_read_status();
    test_wrong_addr();
    test_wrap();
    test_stop_partial();
    test_reset_mid();
    test_glitch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (responder) with a small byte-wide register file, for the MAX10 board controller. It answers an external I2C controller (the SoM MCU or a bench host) on the shared open-drain SCL/SDA pair. It exposes live board status, such as power-good bits, as a read-only register and drives read/write control registers that feed enables and resets. It is the counterpart of the I2C controller in `mcu_system` and uses the same `*_in` / `*_oe` pin split; the top level builds the tristate.

## Interface
Parameters:
- `DEV_ADDR`, 7'h50: 7-bit target address.
- `NREGS`, 8: register count, power of two, range 2..16. Register 0 is STATUS (read-only); registers 1..NREGS-1 are read/write.
- `FILTER_LEN`, 3: SCL/SDA glitch filter length in clocks.

Ports:
- `clk_clk` in 1: system clock; must be at least 20× SCL frequency.
- `reset_reset` in 1: synchronous, active-high reset.
- `scl_in` in 1: raw SCL pin level.
- `sda_in` in 1: raw SDA pin level.
- `sda_oe` out 1: 1 pulls SDA low; 0 releases SDA.
- `status_in` in 8: live value read back as register 0.
- `ctrl_out` out 8*(NREGS-1): registers 1..NREGS-1, packed with reg1 at bits [7:0].
- `wr_strobe` out 1: one-cycle pulse after each accepted data-byte write to register 1 or above.
- `wr_index` out log2(NREGS): register index that goes with `wr_strobe`.
- `busy` out 1: high from START to STOP.

## Operation
- **Input conditioning:** SCL and SDA each pass through a 2-flop synchronizer, then a majority/stable filter. The filter output changes only after the input has held a new level for `FILTER_LEN` clocks. Rise/fall detection works on the filtered signals.
- **START:** SDA falls while SCL is high. A repeated START is legal in any state and goes to ADDR. The bit counter and pointer-phase flag are cleared; the register pointer is kept.
- **STOP:** SDA rises while SCL is high. Valid in any state: go to IDLE, release `sda_oe`, drop `busy`. Any partial byte is discarded.
- **Bit timing:** SDA is sampled on the SCL rising edge. `sda_oe` changes only on an SCL falling edge.
- **FSM states:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
  - **ADDR:** shift in 8 bits, MSB first. If [7:1] == `DEV_ADDR`, go to ADDR_ACK and drive ACK. Otherwise go to IGNORE and leave SDA released until the next START or STOP.
  - **After ADDR_ACK:** if R/W = 0, go to PTR for the first write transaction, then WDATA for later bytes. If R/W = 1, go to RDATA.
  - **PTR:** the received byte's low log2(NREGS) bits load the pointer; upper bits are ignored. The byte is always ACKed.
  - **WDATA:** the byte is ACKed. If pointer ≠ 0, write the register and pulse `wr_strobe`/`wr_index`. Writes to register 0 are ACKed and discarded. The pointer then increments modulo NREGS.
  - **RDATA:** on the falling edge after ACK, load the shift register from register[pointer]. For register 0, take a `status_in` snapshot at that edge. Drive the bits MSB first, with `sda_oe` = ~bit. Release SDA for the controller's ACK, then increment the pointer.
  - **RDATA_ACK:** ACK (SDA low) means go to RDATA with the next byte. NACK means go to IGNORE and wait for STOP or START.
- **Clock stretching:** none. SCL is never driven.

## Timing
- **Reset values:** `sda_oe` = 0, `ctrl_out` = 0, `wr_strobe` = 0, `wr_index` = 0, `busy` = 0, pointer = 0, FSM in IDLE.
- **Input latency:** pin to filtered edge takes 2 + `FILTER_LEN` clocks.
- **SDA drive:** `sda_oe` updates 1 clock after the filtered SCL fall. That gives at least 1 clock of hold after SCL low.
- **ACK window:** `sda_oe` asserts on the SCL fall after bit 0 and releases on the next SCL fall.
- **Write latency:** `ctrl_out` updates and `wr_strobe` pulses on the clock after the SCL rise of bit 0. This is before the ACK is driven.
- **Reset mid-transaction:** on the next clock all state returns to reset values and SDA is released. The block then ignores traffic until a fresh START.
- **SCL/SDA changing together:** SCL edge handling takes priority. START/STOP is detected only while filtered SCL is high and stable.

## Structure
- Package `i2c_target_pkg`: FSM state enum, ACK/NACK constants, `I2C_RW_READ`/`I2C_RW_WRITE`.
- Sub-module `i2c_in_filter`: synchronizer, glitch filter and edge detect. It is instantiated once for SCL and once for SDA.
- Everything else (FSM, shift register, register file) lives in `i2c_target_regs`.

## Test plan
- Write 0x50/W, pointer 0x02, data 0x5A, STOP. Required: three ACKs, `ctrl_out[15:8]` = 0x5A, one `wr_strobe` with `wr_index` = 2.
- With `status_in` = 0xA5: write pointer 0x00, repeated START, 0x50/R, read one byte, controller NACKs, STOP. Required: 0xA5 returned, SDA released after the NACK.
- Address 0x51/W. Required: NACK (SDA high during the ACK bit), no register change, `busy` = 1 until STOP.
- Pointer 0x07, then write 0x11 and 0x22. Required: reg7 = 0x11, pointer wraps to 0, reg0 write ACKed but discarded. A read from pointer 6 with ACK, ACK, NACK returns reg6, 0x11, then 0xA5 (STATUS).
- STOP after 4 bits of a data byte. Required: no write, FSM in IDLE, `sda_oe` = 0.
- Assert `reset_reset` during the RDATA bit-3 low phase. Required: `sda_oe` = 0 on the next clock and `ctrl_out` = 0. A following complete transaction works.
- Inject 1-clock glitches on SCL. Required: no bit-count advance.
